cp0_except_ctrl: RTL and testbench

Exception/interrupt sequencer that drives the CP0 register file's single write port. It samples the MEM-stage exception vector, instruction address and delay-slot flag together with the current CP0 Status/Cause/EPC values and the timer interrupt, and arbitrates the winning event. It then issues the architectural CP0 updates (EPC, Status.EXL, Cause.BD/ExcCode) as a short write sequence, and finally asserts a one-cycle pipeline flush with the handler or return PC.

---
 rtl/cp0_except_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_cp0_except_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_except_ctrl.sv
// cp0_except_ctrl: arbitrates MEM-stage exceptions, interrupts and eret,
// then drives the CP0 register-file write port through a short sequence
// followed by a one-cycle pipeline flush carrying the redirect PC.
module cp0_except_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_valid_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] current_inst_addr_i,
    input  logic        is_in_delayslot_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        timer_int_i,
    output logic        cp0_we_o,
    output logic [4:0]  cp0_waddr_o,
    output logic [31:0] cp0_data_o,
    output logic        stall_req_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        busy_o
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] W_EPC    = 3'd1;
    localparam logic [2:0] W_STATUS = 3'd2;
    localparam logic [2:0] W_CAUSE  = 3'd3;
    localparam logic [2:0] FLUSH    = 3'd4;
    localparam logic [2:0] E_STATUS = 3'd5;

    localparam logic [4:0] ADDR_STATUS = 5'd12;
    localparam logic [4:0] ADDR_CAUSE  = 5'd13;
    localparam logic [4:0] ADDR_EPC    = 5'd14;

    logic [2:0]  state_q, state_d;

    // Event snapshot, held for the whole sequence so inputs may change freely
    logic [4:0]  code_q, code_d;
    logic        bd_q, bd_d;
    logic        eret_q, eret_d;
    logic [31:0] epc_val_q, epc_val_d;
    logic [31:0] status_q, status_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;

    // Next-cycle output values; outputs are flops so they hold a full cycle
    logic        we_d, stall_d, flush_d, busy_d;
    logic [4:0]  waddr_d;
    logic [31:0] data_d, new_pc_d;

    logic [7:0]  ip;
    logic        int_take, exc_hit, eret_hit, load;
    logic [4:0]  code_new;
    logic [31:0] epc_val_new;

    // Event arbitration: interrupt first, then fixed exception order, eret last
    always_comb begin
        ip          = {cp0_cause_i[15:11], cp0_cause_i[10] | timer_int_i, cp0_cause_i[9:8]};
        int_take    = cp0_status_i[0] & ~cp0_status_i[1] & (|(ip & cp0_status_i[15:8]));
        exc_hit     = 1'b1;
        eret_hit    = 1'b0;
        code_new    = 5'h00;
        epc_val_new = is_in_delayslot_i ? current_inst_addr_i - 32'd4 : current_inst_addr_i;
        if (int_take)              code_new = 5'h00;
        else if (excepttype_i[8])  code_new = 5'h08;
        else if (excepttype_i[9])  code_new = 5'h0a;
        else if (excepttype_i[10]) code_new = 5'h0d;
        else if (excepttype_i[11]) code_new = 5'h0c;
        else if (excepttype_i[12]) begin
            exc_hit  = 1'b0;
            eret_hit = 1'b1;
        end else begin
            exc_hit  = 1'b0;
        end
    end

    // Sequencer next state, snapshot capture and next-cycle output decode
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (inst_valid_i && exc_hit) begin
                    state_d = W_EPC;
                    load    = 1'b1;
                end else if (inst_valid_i && eret_hit) begin
                    state_d = E_STATUS;
                    load    = 1'b1;
                end
            end
            W_EPC:    state_d = W_STATUS;
            W_STATUS: state_d = W_CAUSE;
            W_CAUSE:  state_d = FLUSH;
            E_STATUS: state_d = FLUSH;
            FLUSH:    state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        code_d    = load ? code_new          : code_q;
        bd_d      = load ? is_in_delayslot_i : bd_q;
        eret_d    = load ? eret_hit          : eret_q;
        epc_val_d = load ? epc_val_new       : epc_val_q;
        status_d  = load ? cp0_status_i      : status_q;
        cause_d   = load ? cp0_cause_i       : cause_q;
        epc_d     = load ? cp0_epc_i         : epc_q;

        we_d     = 1'b0;
        waddr_d  = 5'd0;
        data_d   = 32'd0;
        stall_d  = 1'b0;
        flush_d  = 1'b0;
        new_pc_d = 32'd0;
        busy_d   = (state_d != IDLE);
        case (state_d)
            W_EPC: begin
                we_d    = 1'b1;
                waddr_d = ADDR_EPC;
                data_d  = epc_val_d;
                stall_d = 1'b1;
            end
            W_STATUS: begin
                we_d    = 1'b1;
                waddr_d = ADDR_STATUS;
                data_d  = status_d | 32'h2;
                stall_d = 1'b1;
            end
            W_CAUSE: begin
                we_d    = 1'b1;
                waddr_d = ADDR_CAUSE;
                data_d  = {bd_d, cause_d[30:7], code_d, 2'b00};
                stall_d = 1'b1;
            end
            E_STATUS: begin
                we_d    = 1'b1;
                waddr_d = ADDR_STATUS;
                data_d  = status_d & ~32'h2;
                stall_d = 1'b1;
            end
            FLUSH: begin
                flush_d  = 1'b1;
                new_pc_d = eret_d ? epc_d : EXC_VECTOR;
            end
            default: ;
        endcase
    end

    // State, snapshot and output registers; reset abandons any sequence
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            code_q      <= 5'd0;
            bd_q        <= 1'b0;
            eret_q      <= 1'b0;
            epc_val_q   <= 32'd0;
            status_q    <= 32'd0;
            cause_q     <= 32'd0;
            epc_q       <= 32'd0;
            cp0_we_o    <= 1'b0;
            cp0_waddr_o <= 5'd0;
            cp0_data_o  <= 32'd0;
            stall_req_o <= 1'b0;
            flush_o     <= 1'b0;
            new_pc_o    <= 32'd0;
            busy_o      <= 1'b0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            bd_q        <= bd_d;
            eret_q      <= eret_d;
            epc_val_q   <= epc_val_d;
            status_q    <= status_d;
            cause_q     <= cause_d;
            epc_q       <= epc_d;
            cp0_we_o    <= we_d;
            cp0_waddr_o <= waddr_d;
            cp0_data_o  <= data_d;
            stall_req_o <= stall_d;
            flush_o     <= flush_d;
            new_pc_o    <= new_pc_d;
            busy_o      <= busy_d;
        end
    end

endmodule

// File: tb/tb_cp0_except_ctrl.sv
// Directed bench for cp0_except_ctrl: each scenario drives one event and
// compares every output, cycle by cycle, against hand-computed values.
module tb_cp0_except_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_valid_i;
    logic [31:0] excepttype_i;
    logic [31:0] current_inst_addr_i;
    logic        is_in_delayslot_i;
    logic [31:0] cp0_status_i;
    logic [31:0] cp0_cause_i;
    logic [31:0] cp0_epc_i;
    logic        timer_int_i;
    logic        cp0_we_o;
    logic [4:0]  cp0_waddr_o;
    logic [31:0] cp0_data_o;
    logic        stall_req_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic        busy_o;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    cp0_except_ctrl dut (
        .clk                 (clk),
        .rst                 (rst),
        .inst_valid_i        (inst_valid_i),
        .excepttype_i        (excepttype_i),
        .current_inst_addr_i (current_inst_addr_i),
        .is_in_delayslot_i   (is_in_delayslot_i),
        .cp0_status_i        (cp0_status_i),
        .cp0_cause_i         (cp0_cause_i),
        .cp0_epc_i           (cp0_epc_i),
        .timer_int_i         (timer_int_i),
        .cp0_we_o            (cp0_we_o),
        .cp0_waddr_o         (cp0_waddr_o),
        .cp0_data_o          (cp0_data_o),
        .stall_req_o         (stall_req_o),
        .flush_o             (flush_o),
        .new_pc_o            (new_pc_o),
        .busy_o              (busy_o)
    );

    // Packed view: {we, waddr, data, stall, flush, new_pc, busy}
    function automatic logic [72:0] obs();
        return {cp0_we_o, cp0_waddr_o, cp0_data_o, stall_req_o, flush_o, new_pc_o, busy_o};
    endfunction

    function automatic logic [72:0] pk(input logic we, input logic [4:0] wa, input logic [31:0] d,
                                       input logic st, input logic fl, input logic [31:0] pc,
                                       input logic bz);
        return {we, wa, d, st, fl, pc, bz};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        inst_valid_i        = 1'b0;
        excepttype_i        = 32'd0;
        current_inst_addr_i = 32'd0;
        is_in_delayslot_i   = 1'b0;
        cp0_status_i        = 32'd0;
        cp0_cause_i         = 32'd0;
        cp0_epc_i           = 32'd0;
        timer_int_i         = 1'b0;
    endtask

    // Drives one exception/interrupt event and checks the 4-cycle sequence
    // plus the idle cycle after it. With noise=1 another event is held on
    // the inputs throughout the busy window; it must be ignored.
    task automatic run_exc(input string name, input logic [31:0] addr, input logic bd,
                           input logic [31:0] status, input logic [31:0] cause,
                           input logic [31:0] ex, input logic tmr, input logic noise,
                           input logic [31:0] e_epc, input logic [31:0] e_status,
                           input logic [31:0] e_cause);
        logic [72:0] exp_c [5];
        exp_c[0] = pk(1'b1, 5'd14, e_epc,    1'b1, 1'b0, 32'd0, 1'b1);
        exp_c[1] = pk(1'b1, 5'd12, e_status, 1'b1, 1'b0, 32'd0, 1'b1);
        exp_c[2] = pk(1'b1, 5'd13, e_cause,  1'b1, 1'b0, 32'd0, 1'b1);
        exp_c[3] = pk(1'b0, 5'd0,  32'd0,    1'b0, 1'b1, 32'h20, 1'b1);
        exp_c[4] = '0;
        inst_valid_i        = 1'b1;
        current_inst_addr_i = addr;
        is_in_delayslot_i   = bd;
        cp0_status_i        = status;
        cp0_cause_i         = cause;
        excepttype_i        = ex;
        timer_int_i         = tmr;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (c == 0) begin
                if (noise) begin
                    current_inst_addr_i = 32'h500;
                    is_in_delayslot_i   = 1'b0;
                    excepttype_i        = 32'h100;
                    cp0_status_i        = 32'h1000_0001;
                end else begin
                    clear_inputs();
                end
            end
            if (c == 3) clear_inputs();
            checks++;
            if (obs() !== exp_c[c])
                $display("FAIL %s cycle%0d got %h expected %h", name, c + 1, obs(), exp_c[c]);
            else
                passes++;
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (obs() !== 73'd0) $display("FAIL reset got %h expected 0", obs());
        else passes++;
        rst = 1'b0;
        inst_valid_i = 1'b1;
        cp0_status_i = 32'h1000_0001;
        current_inst_addr_i = 32'h100;
        tick();
        tick();
        checks++;
        if (obs() !== 73'd0) $display("FAIL idle_no_event got %h expected 0", obs());
        else passes++;
        clear_inputs();
    endtask

    task automatic test_syscall();
        run_exc("syscall", 32'h100, 1'b0, 32'h1000_0001, 32'h0, 32'h100, 1'b0, 1'b0,
                32'h100, 32'h1000_0003, 32'h0000_0020);
    endtask

    task automatic test_overflow_ds();
        run_exc("ovf_ds", 32'h200, 1'b1, 32'h1000_0001, 32'h0, 32'h800, 1'b0, 1'b0,
                32'h1FC, 32'h1000_0003, 32'h8000_0030);
    endtask

    task automatic test_interrupt();
        // timer drives IP2, enabled by IM2 (status bit 10); beats the syscall
        run_exc("timer_int", 32'h300, 1'b0, 32'h1000_0401, 32'h0, 32'h100, 1'b1, 1'b0,
                32'h300, 32'h1000_0403, 32'h0000_0000);
        // pending IP7 in Cause with IM7 set, no instruction exception
        run_exc("ip7_int", 32'h340, 1'b0, 32'h1000_8001, 32'h0000_8000, 32'h0, 1'b0, 1'b0,
                32'h340, 32'h1000_8003, 32'h0000_8000);
        // EXL set: interrupt blocked, syscall taken
        run_exc("int_exl", 32'h380, 1'b0, 32'h1000_0403, 32'h0, 32'h100, 1'b1, 1'b0,
                32'h380, 32'h1000_0403, 32'h0000_0020);
    endtask

    task automatic test_priority();
        run_exc("pri_ri", 32'h600, 1'b0, 32'h1000_0001, 32'h0, 32'hE00, 1'b0, 1'b0,
                32'h600, 32'h1000_0003, 32'h0000_0028);
        run_exc("pri_trap", 32'h604, 1'b0, 32'h1000_0001, 32'h0, 32'hC00, 1'b0, 1'b0,
                32'h604, 32'h1000_0003, 32'h0000_0034);
        run_exc("pri_eret_ovf", 32'h608, 1'b0, 32'h1000_0001, 32'h0, 32'h1800, 1'b0, 1'b0,
                32'h608, 32'h1000_0003, 32'h0000_0030);
    endtask

    task automatic test_eret();
        logic [72:0] exp_c [3];
        exp_c[0] = pk(1'b1, 5'd12, 32'h1000_0001, 1'b1, 1'b0, 32'd0,   1'b1);
        exp_c[1] = pk(1'b0, 5'd0,  32'd0,         1'b0, 1'b1, 32'h400, 1'b1);
        exp_c[2] = '0;
        inst_valid_i        = 1'b1;
        excepttype_i        = 32'h1000;
        current_inst_addr_i = 32'h700;
        cp0_status_i        = 32'h1000_0003;
        cp0_epc_i           = 32'h400;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (c == 0) clear_inputs();
            checks++;
            if (obs() !== exp_c[c])
                $display("FAIL eret cycle%0d got %h expected %h", c + 1, obs(), exp_c[c]);
            else
                passes++;
        end
    endtask

    task automatic test_reset_mid();
        inst_valid_i        = 1'b1;
        excepttype_i        = 32'h100;
        current_inst_addr_i = 32'h800;
        cp0_status_i        = 32'h1000_0001;
        tick();
        clear_inputs();
        tick();
        checks++;
        if (obs() !== pk(1'b1, 5'd12, 32'h1000_0003, 1'b1, 1'b0, 32'd0, 1'b1))
            $display("FAIL rst_mid_wstatus got %h", obs());
        else passes++;
        rst = 1'b1;
        tick();
        checks++;
        if (obs() !== 73'd0) $display("FAIL rst_mid_clear got %h expected 0", obs());
        else passes++;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (obs() !== 73'd0) $display("FAIL rst_mid_noflush c%0d got %h expected 0", c, obs());
            else passes++;
        end
        run_exc("after_rst", 32'h900, 1'b0, 32'h1000_0001, 32'h0, 32'h100, 1'b0, 1'b0,
                32'h900, 32'h1000_0003, 32'h0000_0020);
    endtask

    task automatic test_back_to_back();
        // delay slot at address 0 wraps; a syscall held during busy is ignored
        run_exc("ds_zero", 32'h0, 1'b1, 32'h1000_0001, 32'h0, 32'h200, 1'b0, 1'b1,
                32'hFFFF_FFFC, 32'h1000_0003, 32'h8000_0028);
        tick();
        checks++;
        if (obs() !== 73'd0) $display("FAIL ds_zero_quiet got %h expected 0", obs());
        else passes++;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_syscall();
        test_overflow_ds();
        test_interrupt();
        test_priority();
        test_eret();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
